tx_link_arbiter: RTL and testbench
==================================

Name: tx_link_arbiter

Overview:
- Shares the single UART transmit byte channel between two packet-oriented byte sources.
  - Requester A: trace frame serialiser (high-rate stream).
  - Requester B: housekeeping/stats reporter.
- Grants whole packets; bytes of two packets never interleave.
- Fixed priority to A, with a starvation guard that forces a B packet after STARVE_LIMIT consecutive A packets.
- Sits between the frame/stats producers and the uart transceiver's transmit/tx_byte/tx_free interface.

Parameters:
- STARVE_LIMIT, 4, max consecutive A packets granted while B is pending (1..15).
- TIMEOUT_CYCLES, 4096, idle-valid cycles mid-packet before abort (only with PKT_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (clkOut domain)
- rst  in  1  synchronous, active-low reset; rst==0 resets the block
- a_data  in  8  requester A byte
- a_valid  in  1  A byte valid
- a_last  in  1  A byte is final byte of its packet
- a_ready  out  1  A byte accepted when a_valid&&a_ready
- b_data  in  8  requester B byte
- b_valid  in  1  B byte valid
- b_last  in  1  B byte is final byte of its packet
- b_ready  out  1  B byte accepted when b_valid&&b_ready
- tx_byte  out  8  byte to uart
- transmit  out  1  one-cycle strobe to uart
- tx_free  in  1  uart transmit register available
- grant  out  2  one-hot current owner {B,A}; 0 = none
- busy  out  1  high when state != IDLE
- abort  out  1  one-cycle pulse on packet timeout (0 when feature absent)

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; grant=0; a_ready=b_ready=0; transmit=0; tx_byte=0; busy=0; abort=0; starve_cnt=0; timer=0.
  - Reset mid-packet drops the packet; no further strobes issue.
- States: IDLE, XFER, HOLD.
- IDLE:
  - If b_valid && (!a_valid || starve_cnt>=STARVE_LIMIT): grant=B, starve_cnt<=0.
  - Else if a_valid: grant=A; if b_valid, starve_cnt<=starve_cnt+1 (saturating at STARVE_LIMIT).
  - Either grant moves to XFER next cycle. Neither valid: stay IDLE.
- XFER:
  - Owner ready = tx_free (combinational, registered state only); non-owner ready=0.
  - On owner valid&&ready: tx_byte<=owner data, transmit<=1 for exactly one cycle, last flag latched; state<=HOLD.
- HOLD:
  - Exactly one cycle; transmit returns 0; ready=0.
  - Next state is IDLE (grant<=0) if the latched last=1, else XFER.
- Uart contract: tx_free falls no later than one cycle after transmit; HOLD covers that window.
- Throughput: at most one byte per 2 cycles, further limited by tx_free. Latency from accept to transmit strobe is 1 cycle.
- Packet lock: grant held from first byte to the byte with last=1, regardless of the other requester's valid. Owner dropping valid mid-packet just stalls in XFER.
- Simultaneous a_valid/b_valid in IDLE resolves per the IDLE rule above.
- Single-byte packets (last on the first byte) are legal.
- tx_free low in XFER: no accept, no strobe, state held.
- starve_cnt increments only for A grants made while b_valid was high. It is cleared only by a B grant.

Optional Feature:
- Macro: PKT_TIMEOUT_EN.
- With the macro:
  - A counter runs in XFER while owner valid==0 and resets on any accept.
  - On reaching TIMEOUT_CYCLES-1: abort pulses 1 cycle, grant<=0, state<=IDLE. No transmit is issued for the aborted remainder.
  - The next owner's packet starts clean.
- Without the macro:
  - No counter; abort tied to 0.
  - A stalled owner holds the link indefinitely.

Test Plan:
- Single A packet {0x11,0x22,0x33 last}, tx_free=1, B idle -> transmit strobes with tx_byte 0x11,0x22,0x33 on every 2nd cycle; grant=01 throughout, then 00; busy falls after the last HOLD.
- a_valid and b_valid both asserted in IDLE, starve_cnt=0 -> A granted first. B packet 0xAA (last) transmits only after A's last byte, never interleaved.
- A streams continuous 2-byte packets, B holds a 1-byte packet 0x5C, STARVE_LIMIT=4 -> exactly 4 A packets, then 0x5C, then A resumes; starve_cnt back to 0.
- tx_free held low 10 cycles during XFER -> no a_ready, no transmit; first strobe occurs 1 cycle after the accept following tx_free rising.
- rst driven low in HOLD mid-packet -> next cycle transmit=0, grant=00, ready=0. After release, a fresh B packet is granted first when it is the only valid requester.
- PKT_TIMEOUT_EN, TIMEOUT_CYCLES=16: A sends 1 byte without last, then a_valid=0 -> abort pulses at cycle 16 of stall and grant=00. A pending B packet is granted next; a disabled build stays in XFER.

Source files
------------

// File: rtl/tx_link_arbiter.sv
// -----------------------------------------------------------------------------
// tx_link_arbiter
//
// Shares the single UART transmit byte channel between two packet-oriented
// byte sources: requester A (trace frame serialiser, high rate) and requester B
// (housekeeping/stats reporter). Whole packets are granted, so bytes of two
// packets never interleave. A has fixed priority, but after STARVE_LIMIT
// consecutive A packets granted while B was waiting, B is forced in.
//
// Each accepted byte is registered onto tx_byte with a one-cycle transmit
// strobe, then one HOLD cycle gives the UART time to drop tx_free before the
// next byte can be accepted.
//
// Build option:
//   PKT_TIMEOUT_EN - when defined, an owner that leaves valid low mid-packet
//                    for TIMEOUT_CYCLES cycles loses the link; abort pulses
//                    for one cycle. When undefined, abort is tied to 0 and a
//                    stalled owner holds the link indefinitely.
//
// Parameters:
//   STARVE_LIMIT   - max consecutive A packets granted while B pends (1..15)
//   TIMEOUT_CYCLES - stall cycles before abort (only with PKT_TIMEOUT_EN)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   a_data    in   [7:0] requester A byte
//   a_valid   in   A byte valid
//   a_last    in   A byte ends its packet
//   a_ready   out  A byte accepted when a_valid && a_ready
//   b_data    in   [7:0] requester B byte
//   b_valid   in   B byte valid
//   b_last    in   B byte ends its packet
//   b_ready   out  B byte accepted when b_valid && b_ready
//   tx_byte   out  [7:0] byte to UART
//   transmit  out  one-cycle strobe to UART
//   tx_free   in   UART transmit register available
//   grant     out  [1:0] one-hot owner {B,A}, 0 = none
//   busy      out  arbiter not idle
//   abort     out  one-cycle pulse on packet timeout
// -----------------------------------------------------------------------------
module tx_link_arbiter #(
    parameter int STARVE_LIMIT = 4
`ifdef PKT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_data,
    input  logic       a_valid,
    input  logic       a_last,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_valid,
    input  logic       b_last,
    output logic       b_ready,
    output logic [7:0] tx_byte,
    output logic       transmit,
    input  logic       tx_free,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] starve_q, starve_d;
    logic       last_q, last_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       transmit_q, transmit_d;

`ifdef PKT_TIMEOUT_EN
    localparam int               TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               abort_q, abort_d;
`endif

    // Current owner's byte stream, selected by the registered grant.
    logic       owner_valid;
    logic [7:0] owner_data;
    logic       owner_last;
    logic       owner_ready;
    logic       accept;

    always_comb begin
        owner_valid = grant_q[1] ? b_valid : a_valid;
        owner_data  = grant_q[1] ? b_data  : a_data;
        owner_last  = grant_q[1] ? b_last  : a_last;
        // Ready depends only on registered state and tx_free, never on valid,
        // so there is no combinational loop through the requesters.
        owner_ready = (state_q == XFER) && tx_free;
        accept      = owner_valid && owner_ready;
    end

    assign a_ready = owner_ready && grant_q[0];
    assign b_ready = owner_ready && grant_q[1];

    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves one unassigned; that is what keeps this free of latches.
        state_d    = state_q;
        grant_d    = grant_q;
        starve_d   = starve_q;
        last_d     = last_q;
        tx_byte_d  = tx_byte_q;
        transmit_d = 1'b0;
`ifdef PKT_TIMEOUT_EN
        timer_d    = timer_q;
        abort_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
`ifdef PKT_TIMEOUT_EN
                timer_d = '0;
`endif
                if (b_valid && (!a_valid || starve_q >= STARVE_MAX)) begin
                    grant_d  = GNT_B;
                    starve_d = '0;
                    state_d  = XFER;
                end else if (a_valid) begin
                    grant_d = GNT_A;
                    state_d = XFER;
                    // Only A grants that actually made B wait count toward starvation.
                    if (b_valid && starve_q < STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end

            XFER: begin
                if (accept) begin
                    tx_byte_d  = owner_data;
                    transmit_d = 1'b1;
                    last_d     = owner_last;
                    state_d    = HOLD;
`ifdef PKT_TIMEOUT_EN
                    timer_d    = '0;
                end else if (!owner_valid) begin
                    if (timer_q == TIMER_LAST) begin
                        abort_d = 1'b1;
                        grant_d = GNT_NONE;
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
            end

            HOLD: begin
                // Covers the cycle in which the UART may still show tx_free high.
                if (last_q) begin
                    grant_d = GNT_NONE;
                    state_d = IDLE;
                end else begin
                    state_d = XFER;
                end
            end

            default: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= GNT_NONE;
            starve_q   <= '0;
            last_q     <= 1'b0;
            tx_byte_q  <= '0;
            transmit_q <= 1'b0;
`ifdef PKT_TIMEOUT_EN
            timer_q    <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            starve_q   <= starve_d;
            last_q     <= last_d;
            tx_byte_q  <= tx_byte_d;
            transmit_q <= transmit_d;
`ifdef PKT_TIMEOUT_EN
            timer_q    <= timer_d;
            abort_q    <= abort_d;
`endif
        end
    end

    assign tx_byte  = tx_byte_q;
    assign transmit = transmit_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
`ifdef PKT_TIMEOUT_EN
    assign abort    = abort_q;
`else
    assign abort    = 1'b0;
`endif

endmodule

// File: tb/tb_tx_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tx_link_arbiter
//
// Directed bench for tx_link_arbiter. A negedge monitor logs every transmit
// strobe as {grant, tx_byte}; each scenario compares that log and selected
// cycle-level outputs against hand-written expectations.
// -----------------------------------------------------------------------------
module tb_tx_link_arbiter;

    localparam int BOUND = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, a_ready;
    logic       b_valid, b_last, b_ready;
    logic [7:0] tx_byte;
    logic       transmit, tx_free;
    logic [1:0] grant;
    logic       busy, abort;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [9:0] log_q[$];
    int         log_cyc[$];
    logic [9:0] exp_q[$];

    tx_link_arbiter #(
        .STARVE_LIMIT   (4)
`ifdef PKT_TIMEOUT_EN
      , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_last   (a_last),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_last   (b_last),
        .b_ready  (b_ready),
        .tx_byte  (tx_byte),
        .transmit (transmit),
        .tx_free  (tx_free),
        .grant    (grant),
        .busy     (busy),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (transmit) begin
            log_q.push_back({grant, tx_byte});
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_tx(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    // Compares the strobe log against exp_q, then clears both.
    task automatic check_log(input string tag);
        check({tag, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
        end
        log_q.delete();
        log_cyc.delete();
        exp_q.delete();
    endtask

    // Presents one A byte and returns #1 after the edge that accepted it.
    // valid is left high; the caller drops it or presents the next byte.
    task automatic drive_a(input logic [7:0] d, input logic l);
        int n;
        a_data  = d;
        a_last  = l;
        a_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            check("a_accept_bound", 32'(a_ready), 32'd1);
            a_valid = 1'b0;
        end else begin
            step(1);
        end
    endtask

    task automatic drive_b(input logic [7:0] d, input logic l);
        int n;
        b_data  = d;
        b_last  = l;
        b_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!b_ready) begin
            check("b_accept_bound", 32'(b_ready), 32'd1);
            b_valid = 1'b0;
        end else begin
            step(1);
        end
    endtask

    initial begin
        int viol;
        int n;
        logic seen_abort, seen_bready;

        rst     = 1'b0;
        tx_free = 1'b1;
        a_data  = 8'h00; a_last = 1'b0; a_valid = 1'b1;
        b_data  = 8'h00; b_last = 1'b0; b_valid = 1'b1;

        // ---- Reset state: requesters valid, but nothing may be granted ----
        step(3);
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_a_ready",  32'(a_ready),  32'd0);
        check("rst_b_ready",  32'(b_ready),  32'd0);
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_tx_byte",  32'(tx_byte),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_abort",    32'(abort),    32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b1;
        step(2);
        check("rst_release_log", log_q.size(), 0);

        // ---- Single A packet, strobes every second cycle ----
        drive_a(8'h11, 1'b0);
        drive_a(8'h22, 1'b0);
        drive_a(8'h33, 1'b1);
        a_valid = 1'b0;
        step(3);
        if (log_cyc.size() == 3) begin
            check("t1_gap0", log_cyc[1] - log_cyc[0], 2);
            check("t1_gap1", log_cyc[2] - log_cyc[1], 2);
        end
        expect_tx(2'b01, 8'h11);
        expect_tx(2'b01, 8'h22);
        expect_tx(2'b01, 8'h33);
        check_log("t1_log");
        check("t1_grant_after", 32'(grant), 32'd0);
        check("t1_busy_after",  32'(busy),  32'd0);

        // ---- Simultaneous request: A first, B only after A's last byte ----
        fork
            begin
                drive_a(8'h41, 1'b0);
                drive_a(8'h42, 1'b1);
                a_valid = 1'b0;
            end
            begin
                drive_b(8'hAA, 1'b1);
                b_valid = 1'b0;
            end
        join
        step(3);
        expect_tx(2'b01, 8'h41);
        expect_tx(2'b01, 8'h42);
        expect_tx(2'b10, 8'hAA);
        check_log("t2_log");

        // ---- Starvation guard: 4 A packets, then B, then A resumes ----
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    drive_a(8'(k * 16 + 1), 1'b0);
                    drive_a(8'(k * 16 + 2), 1'b1);
                end
                a_valid = 1'b0;
            end
            begin
                drive_b(8'h5C, 1'b1);
                b_valid = 1'b0;
            end
        join
        step(3);
        for (int k = 1; k <= 4; k++) begin
            expect_tx(2'b01, 8'(k * 16 + 1));
            expect_tx(2'b01, 8'(k * 16 + 2));
        end
        expect_tx(2'b10, 8'h5C);
        for (int k = 5; k <= 6; k++) begin
            expect_tx(2'b01, 8'(k * 16 + 1));
            expect_tx(2'b01, 8'(k * 16 + 2));
        end
        check_log("t3_log");

        // Counter was cleared by the B grant: a fresh contention round must
        // again give A four packets before B.
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    drive_a(8'(8'hC0 + k), 1'b1);
                end
                a_valid = 1'b0;
            end
            begin
                drive_b(8'h5D, 1'b1);
                b_valid = 1'b0;
            end
        join
        step(3);
        for (int k = 1; k <= 4; k++) expect_tx(2'b01, 8'(8'hC0 + k));
        expect_tx(2'b10, 8'h5D);
        expect_tx(2'b01, 8'hC5);
        check_log("t3b_log");

        // ---- tx_free low in XFER: no ready, no strobe ----
        tx_free = 1'b0;
        a_data  = 8'h77;
        a_last  = 1'b1;
        a_valid = 1'b1;
        step(1);
        check("t4_grant", 32'(grant), 32'd1);
        check("t4_busy",  32'(busy),  32'd1);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_ready || transmit) viol++;
            step(1);
        end
        check("t4_stall_violations", viol, 0);
        check("t4_stall_log", log_q.size(), 0);
        check("t4_grant_held", 32'(grant), 32'd1);
        tx_free = 1'b1;
        #1;
        check("t4_ready_on_free", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        check("t4_strobe",  32'(transmit), 32'd1);
        check("t4_tx_byte", 32'(tx_byte),  32'h77);
        step(1);
        check("t4_strobe_one_cycle", 32'(transmit), 32'd0);
        step(2);
        log_q.delete();
        log_cyc.delete();

        // ---- Reset asserted in HOLD mid-packet ----
        a_data  = 8'h91;
        a_last  = 1'b0;
        a_valid = 1'b1;
        step(1);
        step(1);
        check("t5_in_hold_strobe", 32'(transmit), 32'd1);
        rst     = 1'b0;
        a_valid = 1'b0;
        step(1);
        check("t5_transmit", 32'(transmit), 32'd0);
        check("t5_grant",    32'(grant),    32'd0);
        check("t5_a_ready",  32'(a_ready),  32'd0);
        check("t5_b_ready",  32'(b_ready),  32'd0);
        check("t5_busy",     32'(busy),     32'd0);
        step(1);
        log_q.delete();
        log_cyc.delete();
        rst = 1'b1;
        drive_b(8'hB7, 1'b1);
        b_valid = 1'b0;
        step(3);
        expect_tx(2'b10, 8'hB7);
        check_log("t5_log");

        // ---- Owner stalls mid-packet ----
        drive_a(8'hE1, 1'b0);
        a_valid = 1'b0;
        b_data  = 8'hE2;
        b_last  = 1'b1;
        b_valid = 1'b1;
`ifdef PKT_TIMEOUT_EN
        n = 0;
        while (!abort && n < 40) begin
            step(1);
            n++;
        end
        check("t6_abort_cycle", n, 17);
        check("t6_abort_grant", 32'(grant), 32'd0);
        check("t6_abort_busy",  32'(busy),  32'd0);
        step(1);
        check("t6_abort_pulse", 32'(abort), 32'd0);
        check("t6_b_granted",   32'(grant), 32'd2);
        drive_b(8'hE2, 1'b1);
        b_valid = 1'b0;
        step(3);
        expect_tx(2'b01, 8'hE1);
        expect_tx(2'b10, 8'hE2);
        check_log("t6_log");
`else
        seen_abort  = 1'b0;
        seen_bready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (abort)   seen_abort  = 1'b1;
            if (b_ready) seen_bready = 1'b1;
        end
        check("t6_hold_grant",  32'(grant),       32'd1);
        check("t6_hold_busy",   32'(busy),        32'd1);
        check("t6_no_abort",    32'(seen_abort),  32'd0);
        check("t6_no_b_ready",  32'(seen_bready), 32'd0);
        rst     = 1'b0;
        b_valid = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        expect_tx(2'b01, 8'hE1);
        check_log("t6_log");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
